// File: rtl/sb_pkg.sv
// Shared definitions for the register scoreboard.
// Index width default, register count derivation and popcount helper.
package sb_pkg;

    localparam int SB_SEL_W = 3;

    function automatic int sb_nreg(input int sel_w);
        return 2 ** sel_w;
    endfunction

    function automatic logic [6:0] sb_popcount(input logic [63:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < 64; i++) begin
            n = n + {6'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/onehot_decoder.sv
// One-hot decode of an index, qualified by an enable.
// Bit k is high iff en is high and idx equals k.
module onehot_decoder #(
    parameter int SEL_W = 3
) (
    input  logic                  en,
    input  logic [SEL_W-1:0]      idx,
    output logic [(2**SEL_W)-1:0] oh
);

    // Compare the index against every position
    always_comb begin
        oh = '0;
        for (int k = 0; k < 2 ** SEL_W; k++) begin
            oh[k] = en && (idx == SEL_W'(k));
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Register busy scoreboard: tracks pending destinations, flags RAW/WAW stalls.
// Macro SCOREBOARD_BYPASS_EN lets a same-cycle writeback mask the busy bit.
module reg_scoreboard
    import sb_pkg::*;
#(
    parameter  int SEL_W   = SB_SEL_W,
    parameter  bit R0_ZERO = 1'b1,
    localparam int NREG    = sb_nreg(SEL_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             iss_valid,
    input  logic [SEL_W-1:0] iss_dest,
    input  logic             wb_valid,
    input  logic [SEL_W-1:0] wb_dest,
    input  logic [SEL_W-1:0] src_a,
    input  logic [SEL_W-1:0] src_b,
    input  logic             src_a_vld,
    input  logic             src_b_vld,
    output logic             stall_a,
    output logic             stall_b,
    output logic             iss_stall,
    output logic [NREG-1:0]  busy_vec,
    output logic [SEL_W:0]   busy_cnt
);

    localparam int CNT_W = SEL_W + 1;

    logic [NREG-1:0]  busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NREG-1:0]  set_oh, clr_oh, req_oh;
    logic [NREG-1:0]  qa_oh, qb_oh;
    logic [NREG-1:0]  eff_busy;
    logic             set_en;

    assign set_en = iss_valid && !iss_stall;

    onehot_decoder #(.SEL_W(SEL_W)) u_set (
        .en(set_en), .idx(iss_dest), .oh(set_oh)
    );
    onehot_decoder #(.SEL_W(SEL_W)) u_clr (
        .en(wb_valid), .idx(wb_dest), .oh(clr_oh)
    );
    onehot_decoder #(.SEL_W(SEL_W)) u_req (
        .en(iss_valid), .idx(iss_dest), .oh(req_oh)
    );
    onehot_decoder #(.SEL_W(SEL_W)) u_qa (
        .en(src_a_vld), .idx(src_a), .oh(qa_oh)
    );
    onehot_decoder #(.SEL_W(SEL_W)) u_qb (
        .en(src_b_vld), .idx(src_b), .oh(qb_oh)
    );

`ifdef SCOREBOARD_BYPASS_EN
    assign eff_busy = busy_q & ~clr_oh;
`else
    assign eff_busy = busy_q;
`endif

    assign stall_a   = |(qa_oh & eff_busy);
    assign stall_b   = |(qb_oh & eff_busy);
    assign iss_stall = |(req_oh & eff_busy);

    // Next busy state: an issue to an index wins over its writeback,
    // whether it was accepted or stalled on that still-busy index.
    always_comb begin
        busy_d = (busy_q & ~(clr_oh & ~req_oh)) | set_oh;
        if (flush) begin
            busy_d = '0;
        end
        if (R0_ZERO) begin
            busy_d[0] = 1'b0;
        end
        cnt_d = CNT_W'(sb_popcount(64'(busy_d)));
    end

    // Busy bits and their count update together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_vec = busy_q;
    assign busy_cnt = cnt_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard (default SEL_W=3, R0_ZERO=1).
// Behavioural busy-table model plus directed literal checks.
module tb_reg_scoreboard;

    localparam int SW = 3;
    localparam int NR = 8;

`ifdef SCOREBOARD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          iss_valid = 1'b0;
    logic [SW-1:0] iss_dest = '0;
    logic          wb_valid = 1'b0;
    logic [SW-1:0] wb_dest = '0;
    logic [SW-1:0] src_a = '0;
    logic [SW-1:0] src_b = '0;
    logic          src_a_vld = 1'b0;
    logic          src_b_vld = 1'b0;
    logic          stall_a, stall_b, iss_stall;
    logic [NR-1:0] busy_vec;
    logic [SW:0]   busy_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    bit m_busy [NR];

    reg_scoreboard #(.SEL_W(SW), .R0_ZERO(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .iss_valid(iss_valid), .iss_dest(iss_dest),
        .wb_valid(wb_valid), .wb_dest(wb_dest),
        .src_a(src_a), .src_b(src_b),
        .src_a_vld(src_a_vld), .src_b_vld(src_b_vld),
        .stall_a(stall_a), .stall_b(stall_b), .iss_stall(iss_stall),
        .busy_vec(busy_vec), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int m_vec();
        int v = 0;
        for (int k = 0; k < NR; k++) if (m_busy[k]) v |= (1 << k);
        return v;
    endfunction

    function automatic int m_cnt();
        int c = 0;
        for (int k = 0; k < NR; k++) c += int'(m_busy[k]);
        return c;
    endfunction

    // Pending unless a bypassed writeback to the same index retires it now
    function automatic bit m_pend(input bit vld, input int idx);
        bit masked = BYP && wb_valid && (int'(wb_dest) == idx);
        return vld && m_busy[idx] && !masked;
    endfunction

    // Reference busy table: issue request wins, else writeback clears
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NR; k++) m_busy[k] = 1'b0;
        end else if (flush) begin
            for (int k = 0; k < NR; k++) m_busy[k] = 1'b0;
        end else begin
            if (wb_valid) m_busy[wb_dest] = 1'b0;
            if (iss_valid && iss_dest != 0) m_busy[iss_dest] = 1'b1;
        end
    end

    // Compare every live cycle away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            check("cyc_busy_vec", int'(busy_vec), m_vec());
            check("cyc_busy_cnt", int'(busy_cnt), m_cnt());
            check("cyc_stall_a", int'(stall_a),
                  int'(m_pend(src_a_vld, int'(src_a))));
            check("cyc_stall_b", int'(stall_b),
                  int'(m_pend(src_b_vld, int'(src_b))));
            check("cyc_iss_stall", int'(iss_stall),
                  int'(m_pend(iss_valid, int'(iss_dest))));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; iss_valid = 0; wb_valid = 0;
        src_a_vld = 0; src_b_vld = 0;
    endtask

    initial begin
        #3;
        check("rst_busy_vec", int'(busy_vec), 0);
        check("rst_busy_cnt", int'(busy_cnt), 0);
        tick();
        rst_n = 1;

        iss_valid = 1; iss_dest = 5;
        tick();
        idle();
        check("iss5_vec", int'(busy_vec), 'h20);
        check("iss5_cnt", int'(busy_cnt), 1);
        src_a = 5; src_a_vld = 1;
        #1;
        check("raw_stall_a", int'(stall_a), 1);

        idle();
        wb_valid = 1; wb_dest = 5; src_b = 5; src_b_vld = 1;
        #1;
        check("wb_stall_b", int'(stall_b), BYP ? 0 : 1);
        tick();
        idle();
        check("wb5_vec", int'(busy_vec), 0);

        iss_valid = 1; iss_dest = 3;
        tick();
        check("iss3_vec", int'(busy_vec), 'h08);
        wb_valid = 1; wb_dest = 3;
        #1;
        check("waw_iss_stall", int'(iss_stall), BYP ? 0 : 1);
        tick();
        idle();
        check("iss_wb3_vec", int'(busy_vec), 'h08);
        wb_valid = 1; wb_dest = 3;
        tick();
        idle();
        check("wb3_vec", int'(busy_vec), 0);

        wb_valid = 1; wb_dest = 6;
        tick();
        idle();
        check("wb_idle_vec", int'(busy_vec), 0);

        iss_valid = 1; iss_dest = 0;
        #1;
        check("r0_iss_stall", int'(iss_stall), 0);
        tick();
        idle();
        check("r0_vec", int'(busy_vec), 0);
        src_a = 0; src_a_vld = 1;
        #1;
        check("r0_stall_a", int'(stall_a), 0);
        idle();

        for (int r = 1; r < NR; r++) begin
            iss_valid = 1; iss_dest = SW'(r);
            tick();
        end
        idle();
        check("fill_vec", int'(busy_vec), 'hFE);
        check("fill_cnt", int'(busy_cnt), 7);
        flush = 1; iss_valid = 1; iss_dest = 2;
        tick();
        idle();
        check("flush_vec", int'(busy_vec), 0);
        check("flush_cnt", int'(busy_cnt), 0);

        iss_valid = 1; iss_dest = 4;
        tick();
        iss_dest = 1; src_a = 4; src_a_vld = 1;
        #2;
        rst_n = 0;
        #1;
        check("arst_vec", int'(busy_vec), 0);
        check("arst_cnt", int'(busy_cnt), 0);
        check("arst_stall_a", int'(stall_a), 0);
        check("arst_iss_stall", int'(iss_stall), 0);
        @(negedge clk);
        rst_n = 1;
        iss_dest = 6;
        tick();
        idle();
        check("post_rst_vec", int'(busy_vec), 'h40);

        for (int c = 0; c < 400; c++) begin
            iss_valid = 1'($urandom_range(0, 1));
            iss_dest  = SW'($urandom_range(0, NR - 1));
            wb_valid  = 1'($urandom_range(0, 1));
            wb_dest   = SW'($urandom_range(0, NR - 1));
            src_a     = SW'($urandom_range(0, NR - 1));
            src_b     = SW'($urandom_range(0, NR - 1));
            src_a_vld = 1'($urandom_range(0, 1));
            src_b_vld = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 31) == 0);
            tick();
        end
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
